// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered NUM_IN-to-1 word selector with valid/ready output and 2-entry skid buffer
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data [NUM_IN*WIDTH] flattened input words, word k at in_data[k*WIDTH +: WIDTH]
//   in_sel  [SEL_W]        index of the word to forward; >= NUM_IN falls back to DEFAULT_IDX
//   in_valid / in_ready    upstream handshake; in_ready is a pure function of state
//   out_data [WIDTH]       selected word, registered
//   out_sel_err            word was captured with an out-of-range select
//   out_valid / out_ready  downstream handshake
module mux_sel_pipe #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 2,
  parameter int DEFAULT_IDX = 0,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int NW = 1 << SEL_W;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] words [NW];
  logic [WIDTH-1:0] cap_data, skid_data;
  logic sel_err, skid_err, in_xfer, out_xfer, load_main, load_skid;
  // Pad the word table to the full select range so unused codes read the default word.
  for (genvar k = 0; k < NW; k++) begin : g_w
    assign words[k] = in_data[(k < NUM_IN ? k : DEFAULT_IDX)*WIDTH +: WIDTH];
  end
  // Widened by one bit so the compare stays well-formed when NUM_IN fills the select range.
  assign sel_err = {1'b0, in_sel} >= (SEL_W+1)'(NUM_IN);
  assign cap_data = words[in_sel];
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_comb begin
    state_nx = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_xfer;
        state_nx = in_xfer ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_xfer && out_xfer;
        load_skid = in_xfer && !out_xfer;
        state_nx = load_skid ? TWO : (!in_xfer && out_xfer) ? EMPTY : ONE;
      end
      TWO: begin
        load_main = out_xfer;
        state_nx = out_xfer ? ONE : TWO;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  // In TWO the main register refills from the skid entry, otherwise from the live capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel_err <= 1'b0;
      skid_data <= '0;
      skid_err <= 1'b0;
    end else begin
      if (load_main) {out_sel_err, out_data} <= (state == TWO) ? {skid_err, skid_data} : {sel_err, cap_data};
      if (load_skid) {skid_err, skid_data} <= {sel_err, cap_data};
    end
  end
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed and randomized checks of mux_sel_pipe in three configurations
module tb_mux_sel_pipe;
  logic clk, rst_n;
  int total = 0, bad = 0;
  logic [9:0] a_data; logic a_sel, a_valid, a_iready, a_err, a_ovalid, a_oready; logic [4:0] a_odata;
  logic [23:0] b_data; logic [1:0] b_sel; logic b_valid, b_iready, b_err, b_ovalid, b_oready; logic [7:0] b_odata;
  logic [127:0] c_data; logic [2:0] c_sel; logic c_valid, c_iready, c_err, c_ovalid, c_oready; logic [15:0] c_odata;
  logic [16:0] q[$];
  int acc_n = 0, a0;
  bit c_hold = 0;

  mux_sel_pipe u2 (.clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_iready), .out_data(a_odata), .out_sel_err(a_err), .out_valid(a_ovalid), .out_ready(a_oready));
  mux_sel_pipe #(.WIDTH(8), .NUM_IN(3), .DEFAULT_IDX(2)) u3 (.clk(clk), .rst_n(rst_n), .in_data(b_data),
    .in_sel(b_sel), .in_valid(b_valid), .in_ready(b_iready), .out_data(b_odata), .out_sel_err(b_err),
    .out_valid(b_ovalid), .out_ready(b_oready));
  mux_sel_pipe #(.WIDTH(16), .NUM_IN(8)) u8 (.clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel),
    .in_valid(c_valid), .in_ready(c_iready), .out_data(c_odata), .out_sel_err(c_err), .out_valid(c_ovalid),
    .out_ready(c_oready));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: random traffic, 1: valid and ready held high, 2: drain with no new input
  task automatic rand_cycle(input int mode);
    chk("c_ovalid_vs_model", c_ovalid, q.size() > 0);
    chk("c_iready_vs_model", c_iready, q.size() < 2);
    if (mode == 2) c_valid = 0;
    else if (!c_hold) begin
      c_valid = (mode == 1) || $urandom_range(0, 3) != 0;
      c_sel = 3'($urandom);
      c_data = {$urandom, $urandom, $urandom, $urandom};
    end
    c_oready = (mode != 0) || ($urandom % 2 == 1);
    if (c_ovalid && c_oready) begin
      chk("c_pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        chk("c_data", c_odata, q[0][15:0]);
        chk("c_err", c_err, q[0][16]);
        void'(q.pop_front());
      end
    end
    if (c_valid && c_iready) begin
      q.push_back({1'b0, c_data[int'(c_sel)*16 +: 16]});
      acc_n++;
    end
    c_hold = c_valid && !c_iready;
    tick;
  endtask

  initial begin
    rst_n = 0;
    a_data = 0; a_sel = 0; a_valid = 0; a_oready = 0;
    b_data = 0; b_sel = 0; b_valid = 0; b_oready = 0;
    c_data = 0; c_sel = 0; c_valid = 0; c_oready = 0;
    #12;
    chk("rst_ovalid", a_ovalid, 0); chk("rst_odata", a_odata, 0);
    chk("rst_err", a_err, 0); chk("rst_iready", a_iready, 1);
    rst_n = 1;
    tick;
    chk("idle_ovalid", a_ovalid, 0); chk("idle_iready", a_iready, 1);
    // basic select
    a_data = {5'h1A, 5'h05}; a_sel = 1; a_valid = 1; a_oready = 1;
    tick;
    chk("sel1_data", a_odata, 5'h1A); chk("sel1_valid", a_ovalid, 1); chk("sel1_err", a_err, 0);
    a_sel = 0;
    tick;
    chk("sel0_data", a_odata, 5'h05); chk("sel0_valid", a_ovalid, 1);
    a_valid = 0;
    tick;
    chk("empty_ovalid", a_ovalid, 0);
    // back-pressure: 3, 7, 9
    a_oready = 0; a_valid = 1; a_sel = 0; a_data = {5'h0, 5'd3};
    tick;
    chk("bp3_data", a_odata, 3); chk("bp3_iready", a_iready, 1);
    a_data = {5'h0, 5'd7};
    tick;
    chk("bp7_data", a_odata, 3); chk("bp7_iready", a_iready, 0);
    a_data = {5'h0, 5'd9};
    tick;
    chk("bp9_hold_data", a_odata, 3); chk("bp9_iready", a_iready, 0); chk("bp9_ovalid", a_ovalid, 1);
    tick;
    chk("bp9_hold2_data", a_odata, 3);
    a_oready = 1;
    tick;
    chk("drain7_data", a_odata, 7); chk("drain7_iready", a_iready, 1);
    tick;
    chk("drain9_data", a_odata, 9);
    a_valid = 0;
    tick;
    chk("drain_end_ovalid", a_ovalid, 0);
    // reset while both entries are full
    a_oready = 0; a_valid = 1; a_data = {5'h0, 5'h0A};
    tick;
    a_data = {5'h0, 5'h0B};
    tick;
    chk("two_iready", a_iready, 0); chk("two_odata", a_odata, 5'h0A);
    a_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("midrst_ovalid", a_ovalid, 0); chk("midrst_odata", a_odata, 0);
    chk("midrst_err", a_err, 0); chk("midrst_iready", a_iready, 1);
    #2 rst_n = 1;
    tick;
    chk("postrst_ovalid", a_ovalid, 0);
    a_valid = 1; a_oready = 1; a_data = {5'h0, 5'h15};
    tick;
    chk("postrst_data", a_odata, 5'h15); chk("postrst_valid", a_ovalid, 1);
    a_valid = 0;
    tick;
    chk("postrst_no_stale", a_ovalid, 0);
    // out-of-range select, NUM_IN=3, DEFAULT_IDX=2
    b_data = {8'h33, 8'h22, 8'h11}; b_valid = 1; b_oready = 1; b_sel = 3;
    tick;
    chk("oor_data", b_odata, 8'h33); chk("oor_err", b_err, 1);
    b_sel = 1;
    tick;
    chk("in1_data", b_odata, 8'h22); chk("in1_err", b_err, 0);
    b_sel = 0;
    tick;
    chk("in0_data", b_odata, 8'h11); chk("in0_err", b_err, 0);
    b_sel = 2;
    tick;
    chk("in2_data", b_odata, 8'h33); chk("in2_err", b_err, 0);
    b_valid = 0;
    tick;
    chk("b_idle", b_ovalid, 0);
    // random traffic on NUM_IN=8, WIDTH=16
    for (int i = 0; i < 3000 && acc_n < 100; i++) rand_cycle(0);
    chk("c_accepted", acc_n, 100);
    for (int i = 0; i < 5; i++) rand_cycle(2);
    chk("c_drained", q.size(), 0);
    a0 = acc_n;
    c_hold = 0;
    for (int i = 0; i < 30; i++) rand_cycle(1);
    chk("c_throughput", acc_n - a0, 30);
    for (int i = 0; i < 5; i++) rand_cycle(2);
    chk("c_drained2", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
